// File: rtl/row_skew_scheduler.sv
// row_skew_scheduler: buffers per-row operand streams in FIFOs and releases them
// to the systolic array rows with a programmable diagonal stagger. Release is
// gated by i_ready; a one-cycle o_done pulse marks a fully drained tile.

// One array row: a pointer-wrap FIFO followed by the registered output stage.
module row_skew_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_pop_en,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_drop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  pop, wr_acc;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_data  = data_q;
    assign o_valid = valid_q;

    // Pop/write arbitration: a same-cycle pop frees the slot a write into a full FIFO needs.
    always_comb begin
        pop      = i_pop_en && !o_empty;
        wr_acc   = i_wr_en && (!o_full || pop);
        o_drop   = i_wr_en && !wr_acc;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        valid_d  = pop;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            data_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Pointer and output registers; flush empties the FIFO but leaves storage alone.
    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array, written only on accepted writes.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
    end
endmodule

module row_skew_scheduler #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_SKEW   = 3,
    parameter int SKEW_W     = $clog2(MAX_SKEW + 1),
    parameter int CNT_W      = $clog2((ROWS - 1) * MAX_SKEW + 2)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clear,
    input  logic                           i_wr_valid,
    input  logic [$clog2(ROWS)-1:0]        i_wr_row_id,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    input  logic                           i_load_done,
    input  logic                           i_start,
    input  logic [SKEW_W-1:0]              i_skew_step,
    input  logic                           i_ready,
    output logic [ROWS-1:0][DATA_WIDTH-1:0] o_data,
    output logic [ROWS-1:0]                o_data_valid,
    output logic [ROWS-1:0]                o_full,
    output logic                           o_empty,
    output logic                           o_overflow,
    output logic                           o_busy,
    output logic                           o_done
);
    localparam int RID_W = $clog2(ROWS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SKEW_W-1:0] skew_q, skew_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_max;
    logic [ROWS-1:0]   pop_en, empty, drop;
    logic              flush, all_empty;

    assign flush      = i_rst || i_clear;
    assign cnt_max    = CNT_W'(ROWS - 1) * CNT_W'(skew_q);
    assign all_empty  = &empty;
    assign o_empty    = all_empty;
    assign o_overflow = ovf_q;
    assign o_busy     = (state_q == S_RUN);
    assign o_done     = (state_q == S_DONE);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [CNT_W-1:0] thresh;
        logic             wr_en;
        // Row r opens once the stagger counter reaches r*skew.
        assign thresh    = CNT_W'(r) * CNT_W'(skew_q);
        assign pop_en[r] = (state_q == S_RUN) && (cnt_q >= thresh) && i_ready;
        assign wr_en     = i_wr_valid && (i_wr_row_id == RID_W'(r));

        row_skew_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_lane (
            .i_clk    (i_clk),
            .i_flush  (flush),
            .i_wr_en  (wr_en),
            .i_wr_data(i_wr_data),
            .i_pop_en (pop_en[r]),
            .o_data   (o_data[r]),
            .o_valid  (o_data_valid[r]),
            .o_full   (o_full[r]),
            .o_empty  (empty[r]),
            .o_drop   (drop[r])
        );
    end

    // Next state, stagger counter (frozen under backpressure, saturating) and sticky overflow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skew_d  = skew_q;
        ovf_d   = ovf_q || (|drop);
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    skew_d  = i_skew_step;
                end
            end
            S_RUN: begin
                if (cnt_q == cnt_max && all_empty && i_load_done) state_d = S_DONE;
                else if (i_ready && cnt_q != cnt_max) cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; clear aborts any run without a done pulse.
    always_ff @(posedge i_clk) begin
        if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            skew_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_row_skew_scheduler.sv
// Bench for row_skew_scheduler: table of scheduled runs, hand sequences for
// overflow / full write+pop / clear, then random traffic against a queue model.
module tb_row_skew_scheduler;
    localparam int ROWS     = 4;
    localparam int DW       = 8;
    localparam int DEPTH    = 16;
    localparam int MAX_SKEW = 3;
    localparam int SKEW_W   = $clog2(MAX_SKEW + 1);
    localparam int RID_W    = $clog2(ROWS);

    logic                     i_clk = 1'b0;
    logic                     i_rst, i_clear, i_wr_valid, i_load_done, i_start, i_ready;
    logic [RID_W-1:0]         i_wr_row_id;
    logic [DW-1:0]            i_wr_data;
    logic [SKEW_W-1:0]        i_skew_step;
    logic [ROWS-1:0][DW-1:0]  o_data;
    logic [ROWS-1:0]          o_data_valid, o_full;
    logic                     o_empty, o_overflow, o_busy, o_done;

    int n_cmp = 0;
    int n_bad = 0;

    row_skew_scheduler dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_wr_valid(i_wr_valid),
        .i_wr_row_id(i_wr_row_id), .i_wr_data(i_wr_data), .i_load_done(i_load_done),
        .i_start(i_start), .i_skew_step(i_skew_step), .i_ready(i_ready),
        .o_data(o_data), .o_data_valid(o_data_valid), .o_full(o_full), .o_empty(o_empty),
        .o_overflow(o_overflow), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_clear();
        i_clear = 1'b1; i_wr_valid = 1'b0; i_start = 1'b0;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic wr(input int row, input int d);
        i_wr_valid = 1'b1; i_wr_row_id = RID_W'(row); i_wr_data = DW'(d);
        tick();
        i_wr_valid = 1'b0;
    endtask

    task automatic preload3();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < ROWS; r++) wr(r, r * 16 + k);
    endtask

    // ---------------- reference model: queues + integer schedule ----------------
    logic [DW-1:0]           mq [ROWS][$];
    int                      mstate, mcnt, mskew;   // mstate: 0 idle, 1 run, 2 done
    logic [ROWS-1:0][DW-1:0] mdata;
    logic [ROWS-1:0]         mvalid;
    bit                      movf;

    task automatic model_step(input bit clr, input bit wv, input int row, input logic [DW-1:0] d,
                              input bit ld, input bit st, input int sk, input bit rdy);
        bit all_empty;
        bit popped;
        int sat;
        if (clr) begin
            mstate = 0; mcnt = 0; mskew = 0; movf = 0; mdata = '0; mvalid = '0;
            for (int r = 0; r < ROWS; r++) mq[r].delete();
            return;
        end
        all_empty = 1;
        for (int r = 0; r < ROWS; r++) if (mq[r].size() != 0) all_empty = 0;
        sat = (ROWS - 1) * mskew;
        for (int r = 0; r < ROWS; r++) begin
            popped = (mstate == 1) && (mcnt >= r * mskew) && rdy && (mq[r].size() > 0);
            mvalid[r] = popped;
            if (popped) mdata[r] = mq[r].pop_front();
        end
        if (wv) begin
            if (mq[row].size() < DEPTH) mq[row].push_back(d);
            else movf = 1;
        end
        case (mstate)
            0: if (st) begin mstate = 1; mcnt = 0; mskew = sk; end
            1: begin
                if (mcnt == sat && all_empty && ld) mstate = 2;
                else if (rdy && mcnt < sat) mcnt++;
            end
            default: mstate = 0;
        endcase
    endtask

    task automatic model_compare();
        logic [ROWS-1:0] ef;
        bit ee;
        ee = 1;
        for (int r = 0; r < ROWS; r++) begin
            ef[r] = (mq[r].size() == DEPTH);
            if (mq[r].size() != 0) ee = 0;
        end
        check("rnd valid", 64'(o_data_valid), 64'(mvalid));
        check("rnd data", 64'(o_data), 64'(mdata));
        check("rnd full", 64'(o_full), 64'(ef));
        check("rnd empty", 64'(o_empty), 64'(ee));
        check("rnd overflow", 64'(o_overflow), 64'(movf));
        check("rnd busy", 64'(o_busy), 64'(mstate == 1));
        check("rnd done", 64'(o_done), 64'(mstate == 2));
    endtask

    // ---------------- scheduled-run vector table ----------------
    typedef struct {
        int                    skew;
        int                    lo_from;
        int                    lo_to;
        logic [ROWS-1:0][15:0] vm;
        logic [15:0]           busy;
        int                    done_cyc;
    } vec_t;

    function automatic vec_t mk(input int skew, input int lf, input int lt,
                                input logic [15:0] m0, input logic [15:0] m1,
                                input logic [15:0] m2, input logic [15:0] m3,
                                input logic [15:0] busy, input int dc);
        vec_t v;
        v.skew = skew; v.lo_from = lf; v.lo_to = lt;
        v.vm[0] = m0; v.vm[1] = m1; v.vm[2] = m2; v.vm[3] = m3;
        v.busy = busy; v.done_cyc = dc;
        return v;
    endfunction

    vec_t vecs [4];

    initial begin
        logic [ROWS-1:0][15:0] vm;
        logic [15:0] bm, dm;
        int nseen [ROWS];
        int n;
        bit got_done;
        logic [ROWS-1:0] other_v;
        logic [DW-1:0] exp_b;

        // valid-cycle masks per row (bit c = valid during cycle c, start at cycle 0)
        vecs[0] = mk(1, -1, -1, 16'h001C, 16'h0038, 16'h0070, 16'h00E0, 16'h00FE, 8);
        vecs[1] = mk(0, -1, -1, 16'h001C, 16'h001C, 16'h001C, 16'h001C, 16'h001E, 5);
        vecs[2] = mk(1,  4,  5, 16'h001C, 16'h0098, 16'h0190, 16'h0380, 16'h03FE, 10);
        vecs[3] = mk(3, -1, -1, 16'h001C, 16'h00E0, 16'h0700, 16'h3800, 16'h3FFE, 14);

        i_rst = 1'b1; i_clear = 1'b0; i_wr_valid = 1'b0; i_wr_row_id = '0; i_wr_data = '0;
        i_load_done = 1'b0; i_start = 1'b0; i_skew_step = '0; i_ready = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        check("reset data", 64'(o_data), 64'(0));
        check("reset valid", 64'(o_data_valid), 64'(0));
        check("reset full", 64'(o_full), 64'(0));
        check("reset empty", 64'(o_empty), 64'(1));
        check("reset overflow", 64'(o_overflow), 64'(0));
        check("reset busy", 64'(o_busy), 64'(0));
        check("reset done", 64'(o_done), 64'(0));

        // ---- table-driven skew / backpressure runs ----
        for (int i = 0; i < 4; i++) begin
            do_clear();
            preload3();
            i_load_done = 1'b1; i_ready = 1'b1; i_skew_step = SKEW_W'(vecs[i].skew);
            vm = '0; bm = '0; dm = '0;
            for (int r = 0; r < ROWS; r++) nseen[r] = 0;
            i_start = 1'b1;
            for (int c = 0; c < 16; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (o_data_valid[r]) begin
                        vm[r][c] = 1'b1;
                        check($sformatf("vec%0d row%0d data", i, r), 64'(o_data[r]), 64'(r * 16 + nseen[r]));
                        nseen[r]++;
                    end
                end
                bm[c] = o_busy;
                dm[c] = o_done;
                i_ready = !(c >= vecs[i].lo_from && c <= vecs[i].lo_to);
                tick();
                i_start = 1'b0;
            end
            for (int r = 0; r < ROWS; r++)
                check($sformatf("vec%0d row%0d valid cycles", i, r), 64'(vm[r]), 64'(vecs[i].vm[r]));
            check($sformatf("vec%0d busy cycles", i), 64'(bm), 64'(vecs[i].busy));
            check($sformatf("vec%0d done cycle", i), 64'(dm), 64'(16'h1 << vecs[i].done_cyc));
        end

        // ---- overflow: 17 writes into row 1 while idle ----
        do_clear();
        for (int k = 0; k < 16; k++) wr(1, 100 + k);
        check("ovf full after 16", 64'(o_full), 64'(4'b0010));
        check("ovf not yet", 64'(o_overflow), 64'(0));
        wr(1, 200);
        check("ovf sticky set", 64'(o_overflow), 64'(1));
        check("ovf full held", 64'(o_full), 64'(4'b0010));
        i_skew_step = '0; i_load_done = 1'b1; i_ready = 1'b1; i_start = 1'b1;
        n = 0; got_done = 0; other_v = '0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            i_start = 1'b0;
            other_v |= o_data_valid & 4'b1101;
            if (o_data_valid[1]) begin
                check("ovf drain order", 64'(o_data[1]), 64'(100 + n));
                n++;
            end
            if (o_done) got_done = 1;
        end
        check("ovf drained count", 64'(n), 64'(16));
        check("ovf done seen", 64'(got_done), 64'(1));
        check("ovf other rows quiet", 64'(other_v), 64'(0));
        check("ovf still sticky", 64'(o_overflow), 64'(1));
        do_clear();
        check("ovf cleared", 64'(o_overflow), 64'(0));

        // ---- full row, running: write and pop in the same cycle ----
        for (int k = 0; k < 16; k++) wr(0, k);
        i_load_done = 1'b0; i_ready = 1'b0; i_skew_step = '0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("fwp busy", 64'(o_busy), 64'(1));
        i_ready = 1'b1; i_wr_valid = 1'b1; i_wr_row_id = '0; i_wr_data = 8'hAA;
        tick();
        i_wr_valid = 1'b0; i_ready = 1'b0;
        check("fwp valid", 64'(o_data_valid), 64'(4'b0001));
        check("fwp head", 64'(o_data[0]), 64'(0));
        check("fwp still full", 64'(o_full), 64'(4'b0001));
        check("fwp no overflow", 64'(o_overflow), 64'(0));
        tick();
        check("fwp stall no valid", 64'(o_data_valid), 64'(0));
        check("fwp stall full", 64'(o_full), 64'(4'b0001));
        i_ready = 1'b1; i_load_done = 1'b1;
        n = 0; got_done = 0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            if (o_data_valid[0]) begin
                exp_b = (n < 15) ? DW'(n + 1) : 8'hAA;
                check("fwp drain order", 64'(o_data[0]), 64'(exp_b));
                n++;
            end
            if (o_done) got_done = 1;
        end
        check("fwp drained count", 64'(n), 64'(16));
        check("fwp done seen", 64'(got_done), 64'(1));

        // ---- clear mid-run (skew 2), then an empty-FIFO run ----
        do_clear();
        preload3();
        i_load_done = 1'b1; i_ready = 1'b1; i_skew_step = SKEW_W'(2); i_start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) i_clear = 1'b1;
            tick();
            i_start = 1'b0;
        end
        i_clear = 1'b0;
        check("clr busy", 64'(o_busy), 64'(0));
        check("clr valid", 64'(o_data_valid), 64'(0));
        check("clr empty", 64'(o_empty), 64'(1));
        check("clr done", 64'(o_done), 64'(0));
        check("clr data", 64'(o_data), 64'(0));
        dm = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            dm[c] = o_done;
        end
        check("clr no late done", 64'(dm), 64'(0));
        i_skew_step = SKEW_W'(2); i_start = 1'b1; dm = '0;
        for (int c = 0; c < 12; c++) begin
            dm[c] = o_done;
            tick();
            i_start = 1'b0;
            i_skew_step = '0;   // must not alter the latched skew
        end
        check("empty run done cycle", 64'(dm), 64'(16'h1 << (2 + (ROWS - 1) * 2)));

        // ---- random traffic against the model ----
        do_clear();
        model_step(1, 0, 0, '0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit clr, wv, ld, st, rdy;
            int row, sk, rprob;
            logic [DW-1:0] d;
            model_compare();
            rprob = ((cyc / 200) % 2 == 1) ? 15 : 85;
            clr = ($urandom_range(0, 199) == 0);
            wv  = ($urandom_range(0, 1) == 1);
            row = $urandom_range(0, ROWS - 1);
            d   = DW'($urandom);
            ld  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 7) == 0);
            sk  = $urandom_range(0, MAX_SKEW);
            rdy = ($urandom_range(0, 99) < rprob);
            i_clear = clr; i_wr_valid = wv; i_wr_row_id = RID_W'(row); i_wr_data = d;
            i_load_done = ld; i_start = st; i_skew_step = SKEW_W'(sk); i_ready = rdy;
            model_step(clr, wv, row, d, ld, st, sk, rdy);
            tick();
        end
        model_compare();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/row_skew_scheduler.md
# row_skew_scheduler

Parametrised successor to the row group egress stage. It buffers per-row operand streams in internal FIFOs and releases them to the systolic array rows with a runtime-programmable diagonal skew. Release is gated by a downstream-ready backpressure signal, and the block raises a completion pulse once every row has drained. It sits between the input router's address comparators, which are the writers, and the PE array row inputs, which are the readers.

## Interface
- ROWS, 4, number of array rows / FIFOs
- DATA_WIDTH, 8, element width
- FIFO_DEPTH, 16, entries per row FIFO; power of two, ≥2
- MAX_SKEW, 3, largest programmable per-row stagger in cycles
- SKEW_W, $clog2(MAX_SKEW+1), skew field width
- CNT_W, $clog2((ROWS-1)*MAX_SKEW+2), stagger counter width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_clear  in  1  synchronous flush, same effect as reset
- i_wr_valid  in  1  write strobe
- i_wr_row_id  in  $clog2(ROWS)  target row of write
- i_wr_data  in  DATA_WIDTH  write element
- i_load_done  in  1  level; producer has written all elements of the tile
- i_start  in  1  begin release; sampled only in IDLE
- i_skew_step  in  SKEW_W  cycles between successive row enables; latched on accepted start
- i_ready  in  1  downstream accepts data this cycle
- o_data  out  ROWS×DATA_WIDTH  registered per-row element
- o_data_valid  out  ROWS  registered per-row valid
- o_full  out  ROWS  per-row FIFO full
- o_empty  out  1  AND of all FIFO empties
- o_overflow  out  1  sticky; a write hit a full FIFO
- o_busy  out  1  state is RUN
- o_done  out  1  one-cycle completion pulse

## Operation
- FSM has three states: IDLE, RUN and DONE. IDLE goes to RUN on i_start. RUN goes to DONE when the completion condition below holds. DONE always returns to IDLE after one cycle.
- Stagger counter cnt:
  - cleared to 0 on entry to RUN.
  - increments only in RUN with i_ready=1.
  - saturates at (ROWS-1)*skew.
- Row r pop enable: state==RUN and cnt ≥ r*skew. Skew 0 enables all rows simultaneously.
- Pop on row r: pop enable, FIFO r non-empty and i_ready=1. Effect of a pop:
  - o_data[r] loads the FIFO head at the next edge.
  - o_data_valid[r]=1 at that edge.
  - Otherwise o_data_valid[r]=0 and o_data[r] holds its last value.
- Write handling:
  - Writes are accepted in every state.
  - A write to row r is accepted if that FIFO is not full, or if row r pops in the same cycle. In that case the occupancy stays unchanged.
  - Otherwise the write is dropped and o_overflow is set.
  - Simultaneous write and pop on an empty FIFO: the pop is not performed and the write is stored.
- Completion condition (evaluated in RUN): cnt saturated, all FIFOs empty, and i_load_done=1. o_done is a Moore output of state DONE.
- i_start is ignored in RUN and DONE. i_skew_step changes outside an accepted start have no effect.
- i_clear / i_rst (clear takes priority over all other inputs):
  - state returns to IDLE.
  - FIFO pointers, cnt, o_data, o_data_valid and o_overflow are cleared.
  - An in-flight RUN is aborted with no o_done.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with a wrap bit used for full/empty. They wrap modulo 2·FIFO_DEPTH.

## Timing
- Reset values:
  - o_data=0, o_data_valid=0, o_full=0, o_empty=1.
  - o_overflow=0, o_busy=0, o_done=0.
- Start accepted at cycle T. The state is RUN at T+1.
- With i_ready held at 1 and data present, row r gives its first o_data_valid at T+2+r*skew.
- o_data_valid is asserted one cycle after the pop. o_full and o_empty reflect the registered pointers, so they update one cycle after a write or pop.
- Backpressure: a cycle with i_ready=0 has no pops and leaves cnt frozen. Every row's stream therefore shifts by exactly one cycle and the relative skew is preserved.
- o_done is asserted the cycle after the last o_data_valid, provided i_load_done is already high. The state is IDLE one cycle later.
- Throughput: one element per row per cycle.

## Test plan
- Skew 1 with defaults: each row r is preloaded with 3 elements r*16+{0,1,2}, i_load_done=1, i_ready=1, start at cycle 0. Required: row r is valid on cycles 2+r..4+r, in order; o_done at cycle 8; o_busy high on cycles 1–7.
- Skew 0 with the same load: required all rows valid on cycles 2–4 with identical timing, and o_done at cycle 5.
- Skew 1 load with i_ready low on cycles 4–5: required no valids on cycles 5–6, each row's remaining elements shifted by +2 with the skew unchanged, and o_done at cycle 10.
- Write 17 elements to row 1 while IDLE: required o_full[1]=1 after the 16th write, o_overflow=1, and the 17th element dropped. A subsequent run drains exactly 16 elements in order.
- Row full and running: a write and a pop in the same cycle. Required: occupancy remains 16, o_overflow stays 0, and the written element appears last.
- i_clear asserted on cycle 3 of a skew-2 run. Required:
  - next cycle o_busy=0, o_data_valid=0, o_empty=1, and no o_done.
  - a following start with empty FIFOs and i_load_done=1 gives o_done at T+2+(ROWS-1)*2.
